// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module load_store_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LD_RD, RMW_RD, ST_WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b001, 3'b101: return {a[31:1], 1'b0};
      3'b010:         return {a[31:2], 2'b00};
      default:        return a;
    endcase
  endfunction

  // Halfword lanes are always aligned here, so shifting by the byte offset works for both sizes.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] mask, data;
    if (f3 == 3'b000) begin
      mask = 32'h0000_00FF << {a, 3'b000};
      data = {24'h0, wd[7:0]} << {a, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      data = {16'h0, wd[15:0]} << {a[1], 4'b0000};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          addr_d  = MISALIGN_TRAP ? req_addr : align_addr(req_funct3, req_addr);
          if (is_illegal(req_we, req_funct3) ||
              (MISALIGN_TRAP && is_misaligned(req_funct3, req_addr[1:0]))) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (!req_we) begin
            state_d = LD_RD;
          end else if (req_funct3 == 3'b010) begin
            state_d = ST_WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LD_RD: begin
        rdata_d = load_extend(f3_q, addr_q[1:0], mem_read_data);
        err_d   = 1'b0;
        state_d = DONE;
      end
      RMW_RD: begin
        merged_d = store_merge(f3_q, addr_q[1:0], mem_read_data, wdata_q);
        state_d  = ST_WR;
      end
      ST_WR: begin
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write strobe comes straight from state so an async reset kills it before the memory's falling edge.
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == DONE);
  assign resp_err       = err_q;
  assign resp_rdata     = rdata_q;
  assign mem_write_en   = (state_q == ST_WR) && we_q;
  assign mem_addr       = {2'b00, addr_q[31:2]};
  assign mem_write_data = (state_q == ST_WR) ? ((f3_q == 3'b010) ? wdata_q : merged_q) : 32'h0;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory stage and the word-wide data memory. Accepts byte, halfword and word load/store requests (RV32I funct3 encoding). Does sub-word stores as read-modify-write, because the memory only writes whole words. Sign- or zero-extends load data and flags misaligned or illegal requests.

## Interface
- MISALIGN_TRAP, default 1: 1 = misaligned request returns resp_err and performs no memory access; 0 = address low bits forced to natural alignment, access performed, resp_err=0.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted at rising edge when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSBs used for B/H
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3
- resp_rdata  out  32  extended load data; valid with resp_valid for loads
- mem_write_en  out  1  to memory write enable
- mem_addr  out  32  word index = {2'b00, latched_addr[31:2]}
- mem_write_data  out  32  word to write
- mem_read_data  in  32  memory read data; memory captures it on the falling edge of clk

## Operation
- Request fields are latched on acceptance. The latched copies drive everything after that. mem_* outputs decode from state and latched registers.
- States: IDLE, LD_RD, RMW_RD, ST_WR, DONE.
- IDLE, when a request is accepted:
  - illegal or trapped misaligned request -> DONE with err=1
  - load -> LD_RD
  - SW -> ST_WR
  - SB/SH -> RMW_RD
- LD_RD: mem_write_en=0.
  - At the rising edge, the byte/half is selected from mem_read_data and extended into resp_rdata.
  - Then -> DONE.
- RMW_RD: mem_write_en=0.
  - At the rising edge, the merged word is latched: mem_read_data with the target lanes replaced by req_wdata[7:0] or [15:0].
  - Then -> ST_WR.
- ST_WR: mem_write_en=1.
  - mem_write_data = req_wdata (SW) or the merged word.
  - Then -> DONE.
- DONE: resp_valid=1, then -> IDLE.
- Lanes are little-endian.
  - Byte b = addr[1:0] occupies bits [8b+7:8b].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Sign extension:
  - B and H replicate the selected MSB.
  - BU and HU zero-fill.
  - W passes unchanged.
- Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
- Illegal funct3:
  - loads: 011, 110, 111
  - stores: anything other than 000, 001, 010
  - Always resp_err=1 with no access, independent of MISALIGN_TRAP.
- resp_rdata is updated only by loads; otherwise it holds its value. resp_err is cleared by every successful completion.

## Timing
- Request accepted at edge 0; cycle k is the interval after edge k.
- Load: cycle 1 LD_RD, cycle 2 resp_valid.
- SW: cycle 1 ST_WR (write lands on the falling edge of cycle 1), cycle 2 resp_valid.
- SB/SH: cycle 1 RMW_RD, cycle 2 ST_WR, cycle 3 resp_valid.
- Error: cycle 1 resp_valid with resp_err=1. mem_write_en stays 0.
- req_ready returns to 1 in the cycle after resp_valid. There are no back-to-back accepts and no outstanding requests.
- req_valid while not ready is ignored; the requester holds it.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0, mem_addr=0, mem_write_data=0, all latches 0.
- Reset mid-operation:
  - Returns to IDLE immediately, with no resp_valid.
  - If rst_n falls during ST_WR before the falling edge, mem_write_en drops and no write occurs.
  - A partial RMW never writes.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> every output holds its reset value. After release, req_ready=1 and the first accept happens at the next edge.
- SW 0x10, 0xDEADBEEF -> cycle 1: mem_write_en=1, mem_addr=0x4, mem_write_data=0xDEADBEEF. Cycle 2: resp_valid=1, resp_err=0. Then LW 0x10 -> resp_rdata=0xDEADBEEF in cycle 2.
- SB 0x11, wdata 0x000000A5 -> the cycle-2 write is 0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5, and LBU 0x11 -> 0x000000A5.
- SH 0x12, wdata 0x00001234 -> memory word 0x1234A5EF. LH 0x12 -> 0x00001234. LHU 0x10 -> 0x0000A5EF. LH 0x10 -> 0xFFFFA5EF.
- LW 0x13 with MISALIGN_TRAP=1 -> cycle 1: resp_valid=1, resp_err=1, mem_write_en never high, resp_rdata unchanged. Store with funct3 011 -> same result. With MISALIGN_TRAP=0, LW 0x13 -> reads word 0x4, resp_err=0.
- SH 0x10, 0xBEEF on 0x1234A5EF; pull rst_n low in cycle 2 before the falling edge -> mem_write_en=0, memory still 0x1234A5EF, no resp_valid, IDLE after release.
